// File: rtl/btn_sseg_pkg.sv
// Shared types, display constants and the hex-to-segment table for btn_sseg_display.
// Combinational helpers only; no latency, no flow control.
package btn_sseg_pkg;

  typedef enum logic {
    MODE_LATCH = 1'b0,
    MODE_COUNT = 1'b1
  } mode_e;

  localparam logic [7:0] SSEG_IDLE = 8'h80;
  localparam logic [7:0] SSEG_OFF  = 8'h00;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high
  function automatic logic [7:0] sseg_hex(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_sseg_display_debounce.sv
// One button: 2-FF synchroniser, debounce counter, level register and rise pulse.
// Level settles DEBOUNCE_CYCLES+1 edges after raw changes; ena low freezes it (no backpressure).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic db,
  output logic press
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;
  logic            mismatch;
  logic            settle;

  assign mismatch = (sync2 != db);
  assign settle   = mismatch && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
      press <= 1'b0;
    end else begin
      // The synchroniser runs regardless of ena so re-enable sees a settled level
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (ena) begin
        if (!mismatch) begin
          cnt <= '0;
        end else if (settle) begin
          cnt   <= '0;
          db    <= ~db;
          press <= ~db;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/btn_sseg_display.sv
// Debounced pushbuttons drive one 7-segment digit: latch last button index or up/down hex counter.
// btn_db/press at E(D+1), value E(D+2), seg E(D+3); ena low freezes state and blanks seg.
module btn_sseg_display
  import btn_sseg_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             mode,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] press,
  output logic [7:0]       seg
);

  // Only the first three buttons have a meaning in COUNT mode
  localparam int NC = (N_BTN < 3) ? N_BTN : 3;

  logic       mode_s1;
  logic       mode_s2;
  logic       mode_prev;
  logic       mode_chg;
  mode_e      cur_mode;
  logic [3:0] value;
  logic       idle;
  logic [3:0] val_nxt;
  logic       idle_nxt;
  logic [3:0] lat_idx;
  logic [2:0] cnt_btn;
  logic       inc;
  logic       dec;
  logic       clr;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .raw  (btn_raw[i]),
      .db   (btn_db[i]),
      .press(press[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
    end else begin
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
    end
  end

  assign cur_mode = mode_e'(mode_s2);
  assign mode_chg = (mode_s2 != mode_prev);

  assign cnt_btn = 3'(press[NC-1:0]);
  assign inc     = cnt_btn[0];
  assign dec     = cnt_btn[1];
  assign clr     = cnt_btn[2];

  // Descending scan so the lowest pressed index is the one left standing
  always_comb begin
    lat_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press[i]) lat_idx = 4'(i);
    end
  end

  always_comb begin
    val_nxt  = value;
    idle_nxt = idle;
    if (mode_chg) begin
      val_nxt  = 4'h0;
      idle_nxt = 1'b1;
    end else if (cur_mode == MODE_LATCH) begin
      if (|press) begin
        val_nxt  = lat_idx;
        idle_nxt = 1'b0;
      end
    end else begin
      if (clr) begin
        val_nxt  = 4'h0;
        idle_nxt = 1'b0;
      end else if (inc && !dec) begin
        val_nxt  = value + 4'h1;
        idle_nxt = 1'b0;
      end else if (dec && !inc) begin
        val_nxt  = value - 4'h1;
        idle_nxt = 1'b0;
      end else if (inc && dec) begin
        idle_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= 4'h0;
      idle      <= 1'b1;
      mode_prev <= 1'b0;
      seg       <= SSEG_IDLE;
    end else begin
      if (ena) begin
        value     <= val_nxt;
        idle      <= idle_nxt;
        mode_prev <= mode_s2;
      end
      if (!ena) begin
        seg <= SSEG_OFF;
      end else if (idle) begin
        seg <= SSEG_IDLE;
      end else begin
        seg <= sseg_hex(value);
      end
    end
  end

endmodule

// File: doc/btn_sseg_display.md
Name: btn_sseg_display

Overview:
Parametrised successor to the single-digit pushbutton-to-7-segment mapping in the Tiny Tapeout lab top. It takes N_BTN raw pushbutton/switch inputs and synchronises and debounces each one. It converts clean presses into one-cycle press events and drives one active-high 7-segment digit (plus decimal point) from a registered value. Two modes: latch index of last pressed button, or up/down press counter (hex 0-F). Sits inside tt_um_* between ui_in and uo_out.

Parameters:
N_BTN, 4, number of button inputs (1..8).
DEBOUNCE_CYCLES, 4, consecutive stable synced samples required to change a debounced level (>=1).
DB_W, 8, debounce counter width; must satisfy DEBOUNCE_CYCLES <= 2**DB_W - 1.

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  reset; asynchronous assert, active-low; releases synchronously to clk.
ena  input  1  design enable; low freezes debounce counters and value; seg forced to 0.
btn_raw  input  N_BTN  raw button levels, asynchronous to clk, active-high.
mode  input  1  raw static switch: 0 = LATCH, 1 = COUNT; asynchronous to clk.
btn_db  output  N_BTN  debounced button levels (registered).
press  output  N_BTN  one-cycle pulse per debounced rising edge (registered).
seg  output  8  {dp,g,f,e,d,c,b,a}, active-high, registered.

Behaviour:
- Reset (rst_n low, async): sync FFs, btn_db, press, debounce counters and value all 0; idle=1; seg=8'h80 (dp only).
- Sync: each btn_raw bit and mode pass through a 2-FF synchroniser.
- Debounce, per bit: if synced != btn_db, cnt increments. When cnt==DEBOUNCE_CYCLES-1 while still mismatched, btn_db toggles and cnt resets to 0. Any matching sample resets cnt to 0, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: raw first sampled at edge E0 gives btn_db at E(D+1), press high for exactly one cycle from the same edge, value at E(D+2) and seg at E(D+3) (D=DEBOUNCE_CYCLES).
- press[i] rises only on a debounced 0->1 transition. Releases produce no event.
- LATCH mode (synced mode=0):
  - On any press, value <= index of lowest set press bit; idle <= 0.
  - Simultaneous presses: the lowest index wins.
  - No press: value holds.
- COUNT mode (synced mode=1):
  - press[0]: value+1 mod 16.
  - press[1] (if N_BTN>=2): value-1 mod 16.
  - press[2] (if N_BTN>=3): value <= 0.
  - Priority: clear > (inc XOR dec); inc and dec together produce no change.
  - Other bits are ignored. Any handled press clears idle.
  - Wrap: F+1 -> 0, 0-1 -> F.
- Mode change (synced mode differs from previous synced mode): value <= 0 and idle <= 1 on that edge. Presses in the same cycle are discarded.
- seg register:
  - ena=0 gives 0.
  - Else idle=1 gives 8'h80.
  - Else gives HEX(value).
  - HEX table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- ena=0:
  - Synchronisers keep running.
  - Debounce counters, btn_db, value and idle hold; press forced 0.
  - On re-enable, operation resumes with no spurious press.
- value is 4 bits. LATCH index is zero-extended from clog2(N_BTN).
- Reset mid-debounce or mid-press: everything returns to reset values immediately, independent of clk.

Decomposition:
- Package btn_sseg_pkg holds:
  - mode_e enum {MODE_LATCH, MODE_COUNT}.
  - SSEG_IDLE = 8'h80 constant.
  - SSEG_OFF = 8'h00 constant.
  - function sseg_hex(logic [3:0]) returning the table above.
- Sub-module btn_debounce holds one bit of the 2-FF synchroniser, the debounce counter, the level register and the rise-pulse. It is parametrised by DEBOUNCE_CYCLES and DB_W and instantiated N_BTN times via generate.
- Top holds the mode synchroniser and edge detect, value/idle logic and the seg register.

Test Plan:
- Reset, D=4, N_BTN=4, mode=0, all btn low: seg=8'h80, btn_db=0, press=0 for 20 cycles; async rst_n pulse mid-cycle clears outputs immediately.
- LATCH: raise btn_raw[2] at E0 and hold: btn_db[2] and a single press[2] at E5, seg=8'h5B at E7; release gives no seg change.
- Glitch: btn_raw[1] high for 3 cycles then low: btn_db and press stay 0, seg unchanged. Simultaneous btn_raw[3] and btn_raw[1] held: seg=8'h06.
- COUNT: mode=1 gives seg=8'h80 after sync. Three btn0 presses give seg=4F. Four btn1 presses wrap through 0 to F, so seg=8'h71. A btn2 press gives 8'h3F.
- COUNT simultaneous: btn0+btn1 together gives no change. btn0+btn2 together gives 0. Toggle mode back to 0 gives seg=8'h80 and value cleared.
- ena: ena=0 gives seg=0, press=0 while btn held. ena back to 1 restores the prior display with no extra count.
